nibble_serial_tx: RTL and testbench



---
 rtl/nibble_serial_tx.sv | 122 ++++++++++++
 tb/tb_nibble_serial_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// each bit held CLKS_PER_BIT clocks. Strobe-in, busy/done-out handshake.
module nibble_serial_tx #(
   parameter int unsigned DATA_W       = 4,
   parameter int unsigned CLKS_PER_BIT = 2
) (
   input  logic              clc,
   input  logic              Res,
   input  logic              S,
   input  logic [DATA_W-1:0] Y,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic [1:0]        state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [BIT_W-1:0]  bit_idx, bit_idx_nx;
   logic [DATA_W-1:0] shift, shift_nx;
   logic              tx_nx, busy_nx, done_nx;
   logic              bit_end;

   assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

   // Next-state and next-output logic; outputs are only ever driven from flops.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      tx_nx      = tx;
      busy_nx    = busy;
      done_nx    = 1'b0;
      case (state)
         IDLE: begin
            tx_nx   = 1'b1;
            busy_nx = 1'b0;
            cnt_nx  = '0;
            if (S) begin
               state_nx   = START;
               shift_nx   = Y;
               bit_idx_nx = '0;
               tx_nx      = 1'b0;
               busy_nx    = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_nx   = DATA;
               cnt_nx     = '0;
               bit_idx_nx = '0;
               tx_nx      = shift[0];
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_nx = '0;
               if (bit_idx == BIT_W'(DATA_W - 1)) begin
                  state_nx = STOP;
                  tx_nx    = 1'b1;
               end else begin
                  // shift[0] always holds the bit currently on the line
                  shift_nx   = shift >> 1;
                  tx_nx      = shift_nx[0];
                  bit_idx_nx = bit_idx + BIT_W'(1);
               end
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               tx_nx    = 1'b1;
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
            tx_nx    = 1'b1;
            busy_nx  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any frame in progress.
   always_ff @(posedge clc) begin
      if (!Res) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         tx      <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         shift   <= shift_nx;
         tx      <= tx_nx;
         busy    <= busy_nx;
         done    <= done_nx;
      end
   end

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Bench for nibble_serial_tx: per-cycle expected tx/busy/done queued from the
// frame formula when stimulus is driven, popped and checked after each edge.
module tb_nibble_serial_tx;

   typedef struct packed {
      logic tx;
      logic busy;
      logic done;
   } exp_t;

   localparam exp_t IDLE_E = 3'b100;

   logic       clc = 1'b0;
   logic       Res;
   logic       S0, S1;
   logic [3:0] Y0, Y1;
   logic       tx0, busy0, done0;
   logic       tx1, busy1, done1;

   exp_t  q0[$];
   exp_t  q1[$];
   int    n_cmp = 0;
   int    n_err = 0;
   string phase = "init";

   always #5 clc = ~clc;

   nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(2)) u_dut (
      .clc(clc), .Res(Res), .S(S0), .Y(Y0), .tx(tx0), .busy(busy0), .done(done0)
   );

   nibble_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) u_dut_c1 (
      .clc(clc), .Res(Res), .S(S1), .Y(Y1), .tx(tx1), .busy(busy1), .done(done1)
   );

   // Frame of word w at c clocks/bit, starting at the edge after this call.
   task automatic push_frame(input logic [3:0] w, input int c, input int which);
      exp_t e;
      int   b;
      for (int j = 0; j < 6 * c; j++) begin
         b = j / c;
         if (b == 0)      e.tx = 1'b0;
         else if (b <= 4) e.tx = w[b-1];
         else             e.tx = 1'b1;
         e.busy = 1'b1;
         e.done = 1'b0;
         if (which == 0) q0.push_back(e); else q1.push_back(e);
      end
      e = 3'b101;
      if (which == 0) q0.push_back(e); else q1.push_back(e);
   endtask

   task automatic check_one(input string who, input exp_t obs, input exp_t e);
      n_cmp++;
      assert (obs.tx === e.tx) else begin
         n_err++;
         $error("FAIL %s %s tx observed=%b expected=%b", phase, who, obs.tx, e.tx);
      end
      n_cmp++;
      assert (obs.busy === e.busy) else begin
         n_err++;
         $error("FAIL %s %s busy observed=%b expected=%b", phase, who, obs.busy, e.busy);
      end
      n_cmp++;
      assert (obs.done === e.done) else begin
         n_err++;
         $error("FAIL %s %s done observed=%b expected=%b", phase, who, obs.done, e.done);
      end
   endtask

   task automatic step(input int n);
      exp_t e0, e1;
      for (int i = 0; i < n; i++) begin
         @(posedge clc);
         #1;
         e0 = IDLE_E;
         e1 = IDLE_E;
         if (q0.size() > 0) e0 = q0.pop_front();
         if (q1.size() > 0) e1 = q1.pop_front();
         check_one("c2", {tx0, busy0, done0}, e0);
         check_one("c1", {tx1, busy1, done1}, e1);
      end
   endtask

   initial begin
      // Reset with S high and all-ones word: nothing may start.
      phase = "reset";
      Res = 1'b0; S0 = 1'b1; Y0 = 4'b1111; S1 = 1'b1; Y1 = 4'b1111;
      step(2);
      Res = 1'b1; S0 = 1'b0; S1 = 1'b0;
      phase = "post_reset";
      step(3);

      phase = "single_1100";
      Y0 = 4'b1100; S0 = 1'b1; push_frame(4'b1100, 2, 0);
      step(1);
      S0 = 1'b0; Y0 = 4'b0000;
      step(12);
      step(2);

      phase = "busy_ignore";
      Y0 = 4'b0011; S0 = 1'b1; push_frame(4'b0011, 2, 0);
      step(1);
      Y0 = 4'b1111;
      step(10);
      S0 = 1'b0;
      step(2);
      step(3);

      phase = "back_to_back";
      Y0 = 4'b1010; S0 = 1'b1;
      push_frame(4'b1010, 2, 0);
      push_frame(4'b1010, 2, 0);
      push_frame(4'b1010, 2, 0);
      step(38);
      S0 = 1'b0;
      step(3);

      phase = "mid_abort";
      Y0 = 4'b0101; S0 = 1'b1; push_frame(4'b0101, 2, 0);
      step(1);
      S0 = 1'b0;
      step(4);
      Res = 1'b0; q0.delete();
      step(1);
      Res = 1'b1;
      step(3);

      phase = "after_abort_0110";
      Y0 = 4'b0110; S0 = 1'b1; push_frame(4'b0110, 2, 0);
      step(1);
      S0 = 1'b0;
      step(12);
      step(2);

      phase = "c1_1001";
      Y1 = 4'b1001; S1 = 1'b1; push_frame(4'b1001, 1, 1);
      step(1);
      S1 = 1'b0; Y1 = 4'b0000;
      step(6);
      step(2);

      phase = "c1_back_to_back";
      Y1 = 4'b0111; S1 = 1'b1;
      push_frame(4'b0111, 1, 1);
      push_frame(4'b0111, 1, 1);
      step(13);
      S1 = 1'b0;
      step(2);

      phase = "drain";
      n_cmp++;
      assert (q0.size() + q1.size() === 0) else begin
         n_err++;
         $error("FAIL %s queue_left observed=%0d expected=0", phase, q0.size() + q1.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
